hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Pipeline hazard and forwarding control for the 5-stage RV32I core. It tracks destination-register state for the EX, MEM and WB stages and produces the registered 2-bit `forward_a`/`forward_b` selects. These selects drive the two 3-to-1 operand muxes at the ALU inputs. It also detects load-use hazards, inserting a one-cycle bubble and stalling PC and IF/ID, and applies branch flushes. A saturating stall counter supports performance analysis.

## Interface
- `CNT_W`, 16: width of the stall-cycle counter.

- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs1` in 5: rs1 of the instruction in ID.
- `id_rs2` in 5: rs2 of the instruction in ID.
- `id_rd` in 5: rd of the instruction in ID.
- `id_uses_rs1` in 1: the ID instruction reads rs1.
- `id_uses_rs2` in 1: the ID instruction reads rs2.
- `id_reg_write` in 1: the ID instruction writes rd.
- `id_mem_read` in 1: the ID instruction is a load.
- `flush` in 1: branch/jump taken, resolved in EX; kills the ID instruction.
- `stall` out 1: hold PC and IF/ID this cycle (combinational).
- `forward_a` out 2: ALU operand A select for the instruction now in EX.
- `forward_b` out 2: ALU operand B select for the instruction now in EX.
- `ex_bubble` out 1: ID/EX register loads a NOP this cycle (combinational).
- `stall_count` out CNT_W: saturating count of `stall` cycles.

## Operation
- Select encoding:
  - 00: register file value.
  - 01: WB result.
  - 10: MEM-stage ALU result.
  - 11: never driven.
- Internal tracking registers, all shifting every clock:
  - EX stage: `ex_valid`, `ex_rd`, `ex_rw`, `ex_mr`.
  - MEM stage: `mem_rd`, `mem_rw`.
  - WB stage: `wb_rd`, `wb_rw`.
  - MEM takes EX; WB takes MEM.
- Load-use hazard: `hz = id_valid & ex_valid & ex_mr & ex_rw & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))`.
- `stall = hz & ~flush`.
- `ex_bubble = hz | flush`. Flush dominates the stall.
- EX-stage update:
  - On `ex_bubble`: `ex_valid`/`ex_rw`/`ex_mr` load 0 and `ex_rd` loads 0.
  - Otherwise they load `id_valid`, `id_reg_write & id_valid`, `id_mem_read & id_valid` and `id_rd`.
- Forward select computation, done for operand X (rs1 → A, rs2 → B) of the instruction entering EX, at the same edge it enters:
  - If `id_uses_rsX`, `ex_rw`, `ex_rd!=0` and `ex_rd==id_rsX`: next select = 10. That instruction moves to MEM.
  - Else if `id_uses_rsX`, `mem_rw`, `mem_rd!=0` and `mem_rd==id_rsX`: next select = 01. That instruction moves to WB.
  - Else: next select = 00.
  - MEM priority over WB gives youngest-writer-wins.
- On `ex_bubble`, `forward_a` and `forward_b` load 00.
- x0 is never forwarded.
- A register-file write and read in the same cycle is resolved by the register file (write-first). This block never forwards from a stage beyond WB.
- `stall_count` increments on every cycle with `stall=1` and saturates at all-ones.

## Timing
- Reset (`rst=0`), asynchronous:
  - All tracking registers 0.
  - `forward_a` = `forward_b` = 00.
  - `stall_count` = 0.
  - Consequently `stall=0` and `ex_bubble=0` while in reset.
- Registered outputs are valid from the edge where the instruction enters EX and stay constant for its one EX cycle.
- `stall` and `ex_bubble` are combinational in the same cycle as the ID operands, with no added latency.
- A load-use dependency costs exactly one stall cycle:
  - After the bubble, the load sits in WB when the consumer enters EX, so the consumer gets select 01.
  - A loaded value is never selected via 10.
- `flush` with `hz` in the same cycle: `stall=0`, `ex_bubble=1`, and the counter is not incremented.
- Reset deasserted mid-operation: resumes with an empty pipeline. The first ID instruction after reset never stalls.
- Back-to-back loads with the same rd: only the youngest is considered.

## Test plan
- Reset:
  - Stimulus: assert `rst=0` mid-stream with selects at 10.
  - Required: `forward_a`/`forward_b` go to 00 and `stall_count` to 0 immediately (asynchronously). `stall=0`.
- EX→EX forward:
  - Stimulus: `add x5,x1,x2` then `sub x6,x5,x3`.
  - Required: when `sub` is in EX, `forward_a`=10, `forward_b`=00, `stall` never 1.
- WB forward and priority:
  - Stimulus: `addi x7,x0,1`, then `addi x7,x0,2`, then `and x8,x7,x7`.
  - Required: `and` gets A=B=10 (youngest writer).
  - Stimulus: insert a NOP between the second `addi` and `and`.
  - Required: A=B=01.
- Load-use:
  - Stimulus: `lw x9,0(x1)` then `add x10,x9,x9`.
  - Required: `stall=1` and `ex_bubble=1` for exactly one cycle; next cycle `add` in EX with A=B=01; `stall_count`=1.
- x0 and unused operands:
  - Stimulus: `addi x0,x0,5` then `add x3,x0,x0`.
  - Required: selects 00.
  - Stimulus: `lw x4` then `lui x4` (`id_uses_rs1=0`).
  - Required: no stall.
- Flush versus hazard:
  - Stimulus: `lw x9` in EX, dependent in ID, `flush=1` in the same cycle.
  - Required: `stall=0`, `ex_bubble=1`, next EX selects 00, `stall_count` unchanged.
  - Stimulus: force `CNT_W=2` and apply 5 load-use stalls.
  - Required: count saturates at 3.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard and operand-forwarding control for a 5-stage RV32I pipeline.
// Shadows the destination-register state of the instructions in EX and MEM,
// derives the registered ALU operand-mux selects for the instruction entering
// EX, detects load-use hazards (one bubble, PC and IF/ID held), applies branch
// flushes and keeps a saturating count of stall cycles.
//
// Select encoding: 00 register file, 01 WB result, 10 MEM ALU result.
//
// Ports
//   clk           core clock, rising edge
//   rst           asynchronous, active-low reset
//   id_valid      ID holds a real instruction
//   id_rs1/2, rd  register fields of the ID instruction
//   id_uses_rs1/2 ID instruction reads rs1 / rs2
//   id_reg_write  ID instruction writes rd
//   id_mem_read   ID instruction is a load
//   flush         taken branch/jump resolved in EX; kills the ID instruction
//   stall         hold PC and IF/ID this cycle (combinational)
//   forward_a/b   ALU operand A/B select for the instruction now in EX
//   ex_bubble     ID/EX loads a NOP this cycle (combinational)
//   stall_count   saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             ex_bubble,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      SEL_RF  = 2'b00,
      SEL_WB  = 2'b01,
      SEL_MEM = 2'b10
   } fwd_sel_e;

   // Shadow state of the instructions in EX and MEM. The WB stage is not
   // stored: a select of 01 is decided while the producer is still in MEM,
   // and nothing beyond WB is ever forwarded (the register file is
   // write-first), so WB occupancy is never consulted.
   logic             r_ex_valid;
   logic [4:0]       r_ex_rd;
   logic             r_ex_rw;
   logic             r_ex_mr;
   logic [4:0]       r_mem_rd;
   logic             r_mem_rw;
   fwd_sel_e         r_fwd_a;
   fwd_sel_e         r_fwd_b;
   logic [CNT_W-1:0] r_stall_count;

   logic             w_ex_wr_nz;
   logic             w_mem_wr_nz;
   logic             w_hz;
   logic             w_stall;
   logic             w_bubble;
   logic             w_a_from_mem;
   logic             w_a_from_wb;
   logic             w_b_from_mem;
   logic             w_b_from_wb;
   fwd_sel_e         w_fwd_a_nxt;
   fwd_sel_e         w_fwd_b_nxt;

   // A producer only counts if it writes a non-zero register: x0 is never
   // forwarded and never causes a stall.
   assign w_ex_wr_nz  = r_ex_rw  & (r_ex_rd  != 5'd0);
   assign w_mem_wr_nz = r_mem_rw & (r_mem_rd != 5'd0);

   // Load in EX whose result the ID instruction needs next cycle: the data
   // only exists after MEM, so the consumer waits one cycle and picks it up
   // via the WB path.
   assign w_hz = id_valid & r_ex_valid & r_ex_mr & w_ex_wr_nz &
                 ((id_uses_rs1 & (id_rs1 == r_ex_rd)) |
                  (id_uses_rs2 & (id_rs2 == r_ex_rd)));

   // Flush wins: the dependent instruction is being killed anyway, so there
   // is nothing to wait for.
   assign w_stall  = w_hz & ~flush;
   assign w_bubble = w_hz | flush;

   // The EX occupant moves to MEM and the MEM occupant moves to WB at the
   // same edge the ID instruction enters EX; checking EX first makes the
   // youngest writer win.
   assign w_a_from_mem = id_uses_rs1 & w_ex_wr_nz  & (r_ex_rd  == id_rs1);
   assign w_a_from_wb  = id_uses_rs1 & w_mem_wr_nz & (r_mem_rd == id_rs1);
   assign w_b_from_mem = id_uses_rs2 & w_ex_wr_nz  & (r_ex_rd  == id_rs2);
   assign w_b_from_wb  = id_uses_rs2 & w_mem_wr_nz & (r_mem_rd == id_rs2);

   assign w_fwd_a_nxt = w_a_from_mem ? SEL_MEM : (w_a_from_wb ? SEL_WB : SEL_RF);
   assign w_fwd_b_nxt = w_b_from_mem ? SEL_MEM : (w_b_from_wb ? SEL_WB : SEL_RF);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others (EX->MEM shift stays ordered).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex_valid    <= 1'b0;
         r_ex_rd       <= 5'd0;
         r_ex_rw       <= 1'b0;
         r_ex_mr       <= 1'b0;
         r_mem_rd      <= 5'd0;
         r_mem_rw      <= 1'b0;
         r_fwd_a       <= SEL_RF;
         r_fwd_b       <= SEL_RF;
         r_stall_count <= '0;
      end else begin
         r_mem_rd <= r_ex_rd;
         r_mem_rw <= r_ex_rw;

         if (w_bubble) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= 5'd0;
            r_ex_rw    <= 1'b0;
            r_ex_mr    <= 1'b0;
            r_fwd_a    <= SEL_RF;
            r_fwd_b    <= SEL_RF;
         end else begin
            r_ex_valid <= id_valid;
            r_ex_rd    <= id_rd;
            r_ex_rw    <= id_reg_write & id_valid;
            r_ex_mr    <= id_mem_read & id_valid;
            r_fwd_a    <= w_fwd_a_nxt;
            r_fwd_b    <= w_fwd_b_nxt;
         end

         if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign stall       = w_stall;
   assign ex_bubble   = w_bubble;
   assign forward_a   = r_fwd_a;
   assign forward_b   = r_fwd_b;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit. Stimulus drives one ID instruction
// per cycle and pushes the hand-computed responses, tagged with the cycle in
// which they must be visible, into a scoreboard queue. A monitor on the
// falling edge pops every entry due in the current cycle and compares it.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

   typedef enum int { K_STALL, K_BUB, K_FA, K_FB, K_CNT, K_CNT2 } chk_e;

   typedef struct {
      int    cyc;
      chk_e  kind;
      int    exp;
      string name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0;
   logic [4:0]  id_rs2 = '0;
   logic [4:0]  id_rd = '0;
   logic        id_uses_rs1 = 1'b0;
   logic        id_uses_rs2 = 1'b0;
   logic        id_reg_write = 1'b0;
   logic        id_mem_read = 1'b0;
   logic        flush = 1'b0;

   logic        stall;
   logic [1:0]  forward_a;
   logic [1:0]  forward_b;
   logic        ex_bubble;
   logic [15:0] stall_count;

   logic        stall2;
   logic [1:0]  forward_a2;
   logic [1:0]  forward_b2;
   logic        ex_bubble2;
   logic [1:0]  stall_count2;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   hazard_forward_unit #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .stall(stall), .forward_a(forward_a), .forward_b(forward_b),
      .ex_bubble(ex_bubble), .stall_count(stall_count)
   );

   hazard_forward_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .stall(stall2), .forward_a(forward_a2), .forward_b(forward_b2),
      .ex_bubble(ex_bubble2), .stall_count(stall_count2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input integer act, input integer exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic integer f_actual(input chk_e k);
      case (k)
         K_STALL: return integer'(stall);
         K_BUB:   return integer'(ex_bubble);
         K_FA:    return integer'(forward_a);
         K_FB:    return integer'(forward_b);
         K_CNT:   return integer'(stall_count);
         default: return integer'(stall_count2);
      endcase
   endfunction

   // Monitor: compare every expectation due this cycle; anything overdue is
   // reported as a miss.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].name, f_actual(sb[i].kind), sb[i].exp);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            check({sb[i].name, " missed"}, -1, sb[i].exp);
            sb.delete(i);
         end
      end
   end

   task automatic expect_at(input int dc, input chk_e k, input int v, input string name);
      exp_t e;
      e.cyc  = cyc + dc;
      e.kind = k;
      e.exp  = v;
      e.name = name;
      sb.push_back(e);
   endtask

   // Present one instruction in ID for one cycle.
   task automatic id_ins(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit u1, input bit u2,
                         input bit rw, input bit mr, input bit fl);
      @(posedge clk);
      #1;
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      id_reg_write = rw;
      id_mem_read  = mr;
      flush        = fl;
   endtask

   task automatic nop();
      id_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // ---------------- power-on reset ----------------
      #1;
      check("por_fa", forward_a, 0);
      check("por_cnt", stall_count, 0);
      check("por_stall", stall, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // ---------------- EX->EX forward ----------------
      id_ins(1, 1, 2, 5, 1, 1, 1, 0, 0);               // add x5,x1,x2
      expect_at(0, K_STALL, 0, "add_stall");
      expect_at(1, K_FA, 0, "add_fa");
      expect_at(1, K_FB, 0, "add_fb");
      id_ins(1, 5, 3, 6, 1, 1, 1, 0, 0);               // sub x6,x5,x3
      expect_at(0, K_STALL, 0, "sub_stall");
      expect_at(0, K_BUB, 0, "sub_bubble");
      expect_at(1, K_FA, 2, "sub_fa_mem");
      expect_at(1, K_FB, 0, "sub_fb_rf");
      nop(); nop();

      // ---------------- youngest writer wins ----------------
      id_ins(1, 0, 0, 7, 1, 0, 1, 0, 0);               // addi x7,x0,1
      id_ins(1, 0, 0, 7, 1, 0, 1, 0, 0);               // addi x7,x0,2
      id_ins(1, 7, 7, 8, 1, 1, 1, 0, 0);               // and x8,x7,x7
      expect_at(1, K_FA, 2, "and_fa_young");
      expect_at(1, K_FB, 2, "and_fb_young");
      nop(); nop();

      // ---------------- WB forward across a NOP ----------------
      id_ins(1, 0, 0, 7, 1, 0, 1, 0, 0);
      id_ins(1, 0, 0, 7, 1, 0, 1, 0, 0);
      nop();
      id_ins(1, 7, 7, 8, 1, 1, 1, 0, 0);
      expect_at(1, K_FA, 1, "and_fa_wb");
      expect_at(1, K_FB, 1, "and_fb_wb");
      nop(); nop();

      // ---------------- load-use ----------------
      id_ins(1, 1, 0, 9, 1, 0, 1, 1, 0);               // lw x9,0(x1)
      expect_at(0, K_STALL, 0, "lw_stall");
      id_ins(1, 9, 9, 10, 1, 1, 1, 0, 0);              // add x10,x9,x9
      expect_at(0, K_STALL, 1, "lu_stall");
      expect_at(0, K_BUB, 1, "lu_bubble");
      expect_at(0, K_CNT, 0, "lu_cnt_before");
      id_ins(1, 9, 9, 10, 1, 1, 1, 0, 0);              // held in ID
      expect_at(0, K_STALL, 0, "lu_stall_once");
      expect_at(0, K_BUB, 0, "lu_bubble_once");
      expect_at(0, K_FA, 0, "lu_bubble_fa");
      expect_at(0, K_CNT, 1, "lu_cnt");
      expect_at(1, K_FA, 1, "lu_fa_wb");
      expect_at(1, K_FB, 1, "lu_fb_wb");
      nop(); nop();

      // ---------------- x0 and unused operands ----------------
      id_ins(1, 0, 0, 0, 1, 0, 1, 0, 0);               // addi x0,x0,5
      id_ins(1, 0, 0, 3, 1, 1, 1, 0, 0);               // add x3,x0,x0
      expect_at(1, K_FA, 0, "x0_fa");
      expect_at(1, K_FB, 0, "x0_fb");
      nop(); nop();
      id_ins(1, 1, 0, 4, 1, 0, 1, 1, 0);               // lw x4
      id_ins(1, 4, 4, 4, 0, 0, 1, 0, 0);               // lui x4
      expect_at(0, K_STALL, 0, "lui_stall");
      expect_at(0, K_BUB, 0, "lui_bubble");
      expect_at(1, K_FA, 0, "lui_fa");
      nop(); nop();

      // ---------------- flush versus hazard ----------------
      id_ins(1, 1, 0, 9, 1, 0, 1, 1, 0);               // lw x9
      id_ins(1, 9, 9, 10, 1, 1, 1, 0, 1);              // dependent, flushed
      expect_at(0, K_STALL, 0, "fl_stall");
      expect_at(0, K_BUB, 1, "fl_bubble");
      expect_at(1, K_FA, 0, "fl_fa");
      expect_at(1, K_FB, 0, "fl_fb");
      expect_at(1, K_CNT, 1, "fl_cnt");
      nop(); nop();

      // ---------------- counter saturation (2-bit instance) ----------------
      for (int i = 0; i < 5; i++) begin
         id_ins(1, 1, 0, 9, 1, 0, 1, 1, 0);
         id_ins(1, 9, 9, 10, 1, 1, 1, 0, 0);
         id_ins(1, 9, 9, 10, 1, 1, 1, 0, 0);
         expect_at(0, K_CNT2, (i + 2 > 3) ? 3 : i + 2, "sat_cnt2");
      end
      nop();
      expect_at(0, K_CNT, 6, "sat_cnt16");
      expect_at(0, K_CNT2, 3, "sat_cnt2_final");
      nop(); nop();

      // ---------------- asynchronous reset mid-stream ----------------
      id_ins(1, 1, 2, 5, 1, 1, 1, 0, 0);               // add x5,x1,x2
      id_ins(1, 5, 3, 6, 1, 1, 1, 0, 0);               // sub x6,x5,x3
      expect_at(1, K_FA, 2, "pre_rst_sub_fa");
      id_ins(1, 6, 0, 9, 1, 0, 1, 1, 0);               // lw x9,0(x6)
      expect_at(1, K_FA, 2, "pre_rst_lw_fa");
      id_ins(1, 9, 9, 10, 1, 1, 1, 0, 0);              // dependent of lw
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_fa", forward_a, 0);
      check("rst_fb", forward_b, 0);
      check("rst_cnt", stall_count, 0);
      check("rst_cnt2", stall_count2, 0);
      check("rst_stall", stall, 0);
      check("rst_bubble", ex_bubble, 0);
      @(posedge clk);
      #1;
      check("rst_hold_fa", forward_a, 0);
      @(negedge clk);
      rst = 1'b1;
      id_ins(1, 9, 9, 10, 1, 1, 1, 0, 0);
      expect_at(0, K_STALL, 0, "post_rst_stall");
      expect_at(1, K_FA, 0, "post_rst_fa");
      nop(); nop();

      // ---------------- drain ----------------
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      while (sb.size() > 0) begin
         check({sb[0].name, " timeout"}, -1, sb[0].exp);
         void'(sb.pop_front());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
